// File: rtl/mb_scan_ctrl.sv
// Frame scan sequencer: walks the frame macroblock by macroblock and issues one 4-pixel
// row segment per beat (x, y, word address, position flags) with valid/ready handshake.
module mb_scan_ctrl #(
  parameter int unsigned IMGWIDTH  = 64,
  parameter int unsigned IMGHEIGHT = 64,
  parameter int unsigned ADDRW     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      x,
  output logic [31:0]      y,
  output logic [ADDRW-1:0] addr,
  output logic [15:0]      mb_x,
  output logic [15:0]      mb_y,
  output logic             mb_first,
  output logic             mb_last,
  output logic             frame_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic {StIdle, StRun} state_t;

  state_t      r_state;
  logic [3:0]  r_xc;
  logic [3:0]  r_yc;
  logic [31:0] r_xb;
  logic [31:0] r_yb;

  logic [3:0]  w_xc;
  logic [3:0]  w_yc;
  logic [31:0] w_xb;
  logic [31:0] w_yb;
  logic [31:0] w_nx;
  logic [31:0] w_ny;
  logic [15:0] w_mbx;
  logic [15:0] w_mby;
  logic        w_xfer;

  assign w_xfer = out_valid && out_ready;

  // Position of the beat that follows the current one; only consumed on a transfer.
  always_comb begin
    w_xc  = r_xc;
    w_yc  = r_yc;
    w_xb  = r_xb;
    w_yb  = r_yb;
    w_mbx = mb_x;
    w_mby = mb_y;
    if (r_xc < 4'd12) begin
      w_xc = r_xc + 4'd4;
    end else if (r_yc < 4'd15) begin
      w_xc = 4'd0;
      w_yc = r_yc + 4'd1;
    end else if (r_xb < 32'(IMGWIDTH - 16)) begin
      w_xc  = 4'd0;
      w_yc  = 4'd0;
      w_xb  = r_xb + 32'd16;
      w_mbx = mb_x + 16'd1;
    end else begin
      w_xc  = 4'd0;
      w_yc  = 4'd0;
      w_xb  = 32'd0;
      w_yb  = r_yb + 32'd16;
      w_mbx = 16'd0;
      w_mby = mb_y + 16'd1;
    end
    w_nx = w_xb + {28'd0, w_xc};
    w_ny = w_yb + {28'd0, w_yc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_xc       <= 4'd0;
      r_yc       <= 4'd0;
      r_xb       <= 32'd0;
      r_yb       <= 32'd0;
      out_valid  <= 1'b0;
      x          <= 32'd0;
      y          <= 32'd0;
      addr       <= '0;
      mb_x       <= 16'd0;
      mb_y       <= 16'd0;
      mb_first   <= 1'b0;
      mb_last    <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Coordinates are already zero whenever the block sits in idle.
          if (start) begin
            r_state   <= StRun;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            mb_first  <= 1'b1;
          end
        end
        StRun: begin
          if (abort || (w_xfer && frame_last)) begin
            r_state    <= StIdle;
            done       <= !abort;
            r_xc       <= 4'd0;
            r_yc       <= 4'd0;
            r_xb       <= 32'd0;
            r_yb       <= 32'd0;
            out_valid  <= 1'b0;
            x          <= 32'd0;
            y          <= 32'd0;
            addr       <= '0;
            mb_x       <= 16'd0;
            mb_y       <= 16'd0;
            mb_first   <= 1'b0;
            mb_last    <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
          end else if (w_xfer) begin
            r_xc       <= w_xc;
            r_yc       <= w_yc;
            r_xb       <= w_xb;
            r_yb       <= w_yb;
            x          <= w_nx;
            y          <= w_ny;
            addr       <= ADDRW'((w_ny * IMGWIDTH + w_nx) >> 2);
            mb_x       <= w_mbx;
            mb_y       <= w_mby;
            mb_first   <= (w_xc == 4'd0) && (w_yc == 4'd0);
            mb_last    <= (w_xc == 4'd12) && (w_yc == 4'd15);
            frame_last <= (w_nx == 32'(IMGWIDTH - 4)) && (w_ny == 32'(IMGHEIGHT - 1));
          end
        end
      endcase
    end
  end

endmodule
